// File: rtl/wb_pkg.sv
// wb_pkg: writeback source encoding and default datapath width shared by the writeback stage
package wb_pkg;
   localparam int XLEN_DEFAULT = 64;
   typedef enum logic [1:0] {
      WB_ALU  = 2'd0,
      WB_MEM  = 2'd1,
      WB_PC4  = 2'd2,
      WB_NONE = 2'd3
   } wb_sel_t;
endpackage

// File: rtl/retire_counter.sv
// retire_counter: free-running 64-bit retired-instruction counter, wraps silently
module retire_counter (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc,
   output logic [63:0] count
);
   logic [63:0] count_q, count_d;
   // advance by one per retirement; overflow wraps to zero
   always_comb count_d = inc ? count_q + 64'd1 : count_q;
   // counter register, cleared immediately by reset
   always_ff @(posedge clk or posedge rst)
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   assign count = count_q;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register and writeback mux; define WB_FORWARD_EN to add forwarding outputs
module mem_wb_stage
   import wb_pkg::*;
#(
   parameter int XLEN       = XLEN_DEFAULT,
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [XLEN-1:0]       dm_read_data,
   input  logic [XLEN-1:0]       dm_data_bypass,
   input  logic [XLEN-1:0]       pc_plus4,
   input  logic [REG_ADDR_W-1:0] rd_addr,
   input  logic                  rd_write_en,
   input  wb_sel_t               wb_sel,
   output logic                  rf_write_en,
   output logic [REG_ADDR_W-1:0] rf_write_addr,
   output logic [XLEN-1:0]       rf_write_data,
   output logic                  wb_valid,
`ifdef WB_FORWARD_EN
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_addr,
   output logic [XLEN-1:0]       fwd_data,
`endif
   output logic [63:0]           instret_count
);
   logic                  valid_q, valid_d, we_q, we_d;
   logic [REG_ADDR_W-1:0] addr_q, addr_d;
   logic [XLEN-1:0]       data_q, data_d, sel_data;
   wb_sel_t               sel_q, sel_d;
   logic                  retire;
   // select writeback data, then apply flush > stall > capture
   always_comb begin
      sel_data = wb_sel == WB_ALU ? dm_data_bypass :
                 wb_sel == WB_MEM ? dm_read_data   :
                 wb_sel == WB_PC4 ? pc_plus4       : '0;
      valid_d  = flush ? 1'b0 : stall ? valid_q : in_valid;
      we_d     = stall ? we_q   : rd_write_en;
      addr_d   = stall ? addr_q : rd_addr;
      data_d   = stall ? data_q : sel_data;
      sel_d    = stall ? sel_q  : wb_sel;
      retire   = in_valid & ~stall & ~flush;
   end
   // stage register; reset discards any in-flight instruction
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         sel_q   <= WB_ALU;
      end else begin
         valid_q <= valid_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
      end
   assign wb_valid      = valid_q;
   assign rf_write_addr = addr_q;
   assign rf_write_data = data_q;
   assign rf_write_en   = valid_q & we_q & (sel_q != WB_NONE) & (|addr_q);
`ifdef WB_FORWARD_EN
   assign fwd_valid = rf_write_en;
   assign fwd_addr  = rf_write_addr;
   assign fwd_data  = rf_write_data;
`endif
   retire_counter u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (retire),
      .count (instret_count)
   );
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: randomized self-checking bench for mem_wb_stage against a spec-level model
module tb_mem_wb_stage;
   import wb_pkg::*;
   localparam int XLEN = 64;
   localparam int RW   = 5;
   logic            clk = 0, rst = 1, stall = 0, flush = 0, in_valid = 0, rd_write_en = 0;
   logic [XLEN-1:0] dm_read_data = '0, dm_data_bypass = '0, pc_plus4 = '0;
   logic [RW-1:0]   rd_addr = '0;
   wb_sel_t         wb_sel = WB_ALU;
   logic            rf_write_en, wb_valid;
   logic [RW-1:0]   rf_write_addr;
   logic [XLEN-1:0] rf_write_data;
   logic [63:0]     instret_count;
`ifdef WB_FORWARD_EN
   logic            fwd_valid;
   logic [RW-1:0]   fwd_addr;
   logic [XLEN-1:0] fwd_data;
`endif
   int passed = 0, total = 0;
   bit              m_valid, m_we, m_none;
   logic [RW-1:0]   m_addr;
   logic [XLEN-1:0] m_data;
   logic [63:0]     m_cnt;

   always #5 clk = ~clk;

   mem_wb_stage #(.XLEN(XLEN), .REG_ADDR_W(RW)) dut (
      .clk            (clk),
      .rst            (rst),
      .stall          (stall),
      .flush          (flush),
      .in_valid       (in_valid),
      .dm_read_data   (dm_read_data),
      .dm_data_bypass (dm_data_bypass),
      .pc_plus4       (pc_plus4),
      .rd_addr        (rd_addr),
      .rd_write_en    (rd_write_en),
      .wb_sel         (wb_sel),
      .rf_write_en    (rf_write_en),
      .rf_write_addr  (rf_write_addr),
      .rf_write_data  (rf_write_data),
      .wb_valid       (wb_valid),
`ifdef WB_FORWARD_EN
      .fwd_valid      (fwd_valid),
      .fwd_addr       (fwd_addr),
      .fwd_data       (fwd_data),
`endif
      .instret_count  (instret_count)
   );

   task automatic set_in(bit v, wb_sel_t s, logic [RW-1:0] rd, bit we,
                         logic [63:0] mem, logic [63:0] byp, logic [63:0] pc, bit st, bit fl);
      in_valid = v; wb_sel = s; rd_addr = rd; rd_write_en = we;
      dm_read_data = mem; dm_data_bypass = byp; pc_plus4 = pc; stall = st; flush = fl;
   endtask

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   task automatic model_reset();
      m_valid = 0; m_we = 0; m_none = 0; m_addr = '0; m_data = '0; m_cnt = '0;
   endtask

   task automatic step();
      @(posedge clk);
      if (rst) model_reset();
      else begin
         if (in_valid && !stall && !flush) m_cnt = m_cnt + 64'd1;
         if (flush) m_valid = 0;
         else if (!stall) begin
            m_valid = in_valid;
            m_we    = rd_write_en;
            m_addr  = rd_addr;
            m_none  = (wb_sel == WB_NONE);
            case (wb_sel)
               WB_ALU:  m_data = dm_data_bypass;
               WB_MEM:  m_data = dm_read_data;
               WB_PC4:  m_data = pc_plus4;
               default: m_data = '0;
            endcase
         end
      end
      #1;
   endtask

   function automatic bit exp_we();
      return m_valid && m_we && !m_none && (m_addr != 0);
   endfunction

   task automatic test_reset();
      #1;
      total++;
      if ({wb_valid, rf_write_en, rf_write_addr, rf_write_data, instret_count} !== '0)
         $display("FAIL reset_initial: got v=%b we=%b a=%0d d=%h n=%0d expected all 0", wb_valid, rf_write_en, rf_write_addr, rf_write_data, instret_count);
      else passed++;
      #2 rst = 0;
      model_reset();
      set_in(1, WB_ALU, 3, 1, r64(), 64'h55, r64(), 0, 0);
      step();
      total++;
      if (wb_valid !== 1'b1 || rf_write_en !== 1'b1) $display("FAIL reset_pre_valid: got v=%b we=%b expected 1 1", wb_valid, rf_write_en);
      else passed++;
      #3 rst = 1;
      #1;
      total++;
      if ({wb_valid, rf_write_en, rf_write_addr, rf_write_data, instret_count} !== '0)
         $display("FAIL reset_async: got v=%b we=%b a=%0d d=%h n=%0d expected all 0", wb_valid, rf_write_en, rf_write_addr, rf_write_data, instret_count);
      else passed++;
      model_reset();
      rst = 0;
      step();
      total++;
      if (wb_valid !== 1'b1 || instret_count !== 64'd1 || rf_write_data !== 64'h55)
         $display("FAIL reset_first_capture: got v=%b n=%0d d=%h expected 1 1 55", wb_valid, instret_count, rf_write_data);
      else passed++;
   endtask

   task automatic test_load();
      logic [63:0] c0 = m_cnt;
      set_in(1, WB_MEM, 5, 1, 64'hFFFF_FFFF_FFFF_FF80, r64(), r64(), 0, 0);
      step();
      total++;
      if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd5 || rf_write_data !== 64'hFFFF_FFFF_FFFF_FF80)
         $display("FAIL load: got we=%b a=%0d d=%h expected 1 5 ffffffffffffff80", rf_write_en, rf_write_addr, rf_write_data);
      else passed++;
      total++;
      if (instret_count !== c0 + 64'd1) $display("FAIL load_instret: got %0d expected %0d", instret_count, c0 + 64'd1);
      else passed++;
   endtask

   task automatic test_x0();
      logic [63:0] c0 = m_cnt;
      set_in(1, WB_ALU, 0, 1, r64(), 64'h1234, r64(), 0, 0);
      step();
      total++;
      if (rf_write_en !== 1'b0 || wb_valid !== 1'b1 || rf_write_data !== 64'h1234)
         $display("FAIL x0_write: got we=%b v=%b d=%h expected 0 1 1234", rf_write_en, wb_valid, rf_write_data);
      else passed++;
      total++;
      if (instret_count !== c0 + 64'd1) $display("FAIL x0_instret: got %0d expected %0d", instret_count, c0 + 64'd1);
      else passed++;
   endtask

   task automatic test_stall_flush();
      logic [63:0] c;
      set_in(1, WB_PC4, 1, 1, r64(), r64(), 64'h1004, 0, 0);
      step();
      c = m_cnt;
      total++;
      if (rf_write_en !== 1'b1 || rf_write_addr !== 5'd1 || rf_write_data !== 64'h1004)
         $display("FAIL jal_capture: got we=%b a=%0d d=%h expected 1 1 1004", rf_write_en, rf_write_addr, rf_write_data);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         set_in(1, wb_sel_t'($urandom_range(0, 3)), RW'($urandom), 1'($urandom), r64(), r64(), r64(), 1, 0);
         step();
         total++;
         if (wb_valid !== 1'b1 || rf_write_en !== 1'b1 || rf_write_addr !== 5'd1 || rf_write_data !== 64'h1004 || instret_count !== c)
            $display("FAIL stall_hold[%0d]: got v=%b we=%b a=%0d d=%h n=%0d expected 1 1 1 1004 %0d", i, wb_valid, rf_write_en, rf_write_addr, rf_write_data, instret_count, c);
         else passed++;
      end
      set_in(1, WB_ALU, 9, 1, r64(), r64(), r64(), 1, 1);
      step();
      total++;
      if (wb_valid !== 1'b0 || rf_write_en !== 1'b0 || instret_count !== c)
         $display("FAIL stall_flush: got v=%b we=%b n=%0d expected 0 0 %0d", wb_valid, rf_write_en, instret_count, c);
      else passed++;
   endtask

   task automatic test_wrap();
      set_in(0, WB_ALU, 0, 0, '0, '0, '0, 0, 0);
      step();
      force dut.u_cnt.count_q = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.u_cnt.count_q;
      #1;
      m_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
      total++;
      if (instret_count !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL wrap_preload: got %h expected ffffffffffffffff", instret_count);
      else passed++;
      set_in(1, WB_ALU, 2, 0, r64(), r64(), r64(), 0, 0);
      step();
      total++;
      if (instret_count !== 64'd0) $display("FAIL wrap: got %h expected 0", instret_count);
      else passed++;
   endtask

   task automatic test_back_to_back();
      logic [63:0] v [4];
      for (int i = 0; i < 4; i++) v[i] = r64();
      for (int i = 0; i < 4; i++) begin
         set_in(1, wb_sel_t'(i), RW'(i + 10), 1, v[1], v[0], v[2], 0, 0);
         step();
         total++;
         if (rf_write_data !== (i == 3 ? 64'd0 : v[i]) || rf_write_en !== (i != 3) || rf_write_addr !== RW'(i + 10))
            $display("FAIL back_to_back[%0d]: got we=%b a=%0d d=%h expected %b %0d %h", i, rf_write_en, rf_write_addr, rf_write_data, i != 3, i + 10, i == 3 ? 64'd0 : v[i]);
         else passed++;
      end
   endtask

`ifdef WB_FORWARD_EN
   task automatic test_forward();
      set_in(1, WB_ALU, 7, 1, r64(), 64'hABCD, r64(), 0, 0);
      step();
      total++;
      if (fwd_valid !== 1'b1 || rf_write_en !== 1'b1 || fwd_addr !== 5'd7 || fwd_data !== 64'hABCD)
         $display("FAIL forward: got fv=%b we=%b fa=%0d fd=%h expected 1 1 7 abcd", fwd_valid, rf_write_en, fwd_addr, fwd_data);
      else passed++;
   endtask
`endif

   task automatic test_random();
      for (int i = 0; i < 300; i++) begin
         set_in($urandom_range(0, 3) != 0, wb_sel_t'($urandom_range(0, 3)),
                ($urandom_range(0, 4) == 0) ? RW'(0) : RW'($urandom), 1'($urandom),
                r64(), r64(), r64(), $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         step();
         total++;
         if (wb_valid !== m_valid || rf_write_en !== exp_we() || instret_count !== m_cnt)
            $display("FAIL random[%0d]: got v=%b we=%b n=%0d expected %b %b %0d", i, wb_valid, rf_write_en, instret_count, m_valid, exp_we(), m_cnt);
         else passed++;
         if (m_valid) begin
            total++;
            if (rf_write_addr !== m_addr || rf_write_data !== m_data)
               $display("FAIL random_data[%0d]: got a=%0d d=%h expected %0d %h", i, rf_write_addr, rf_write_data, m_addr, m_data);
            else passed++;
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      model_reset();
      test_reset();
      test_load();
      test_x0();
      test_stall_flush();
      test_wrap();
      test_back_to_back();
`ifdef WB_FORWARD_EN
      test_forward();
`endif
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
